// File: rtl/dds_capture_readout_if.sv
// Readout stream of the DDS capture buffer: one 43-bit record per valid/ready transfer.
interface dds_capture_readout_if #(
  parameter int ADDR_W = 10
);
  logic [42:0]       rd_data;
  logic [ADDR_W-1:0] rd_index;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output rd_data,
    output rd_index,
    output rd_valid,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_index,
    input  rd_valid,
    input  rd_last,
    output rd_ready
  );
endinterface

// File: rtl/dds_capture_readout.sv
// Captures one shot of DEPTH Top-DDS output records (sine, tri, pwm1..4) into a
// block-RAM buffer, either immediately or on a rising zero crossing of sine,
// with optional decimation, then replays the shot over a valid/ready stream.
module dds_capture_readout #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                trig_mode,
  input  logic [DECIM_W-1:0]  decim,
  input  logic signed [15:0]  sine_in,
  input  logic signed [16:0]  tri_in,
  input  logic                pwm1_in,
  input  logic                pwm2_in,
  input  logic signed [3:0]   pwm3_in,
  input  logic signed [3:0]   pwm4_in,
  output logic                busy,
  output logic                done,
  dds_capture_readout_if.master rd
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_READOUT = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]         state;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dcnt;
  logic [ADDR_W-1:0]  wr_ptr;
  logic signed [15:0] prev_sine;

  logic [42:0]        mem [DEPTH];
  logic [42:0]        ram_q;

  // Readout pipeline: rd_start marks the READOUT entry cycle, rd_req issues the
  // first buffer read one cycle later so the first record shows two cycles in.
  logic               rd_start;
  logic               rd_req;
  logic               valid_q;
  logic               last_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               done_q;

  logic               trig_hit;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [42:0]        wr_data;
  logic               xfer;
  logic               rd_ld;
  logic [ADDR_W-1:0]  rd_addr;

  // Write-port steering and read-port control derived from the current state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_en    = 1'b0;
    wr_addr  = wr_ptr;
    wr_data  = {sine_in, tri_in, pwm1_in, pwm2_in, pwm3_in, pwm4_in};
    trig_hit = (prev_sine < 0) && (sine_in >= 0);
    case (state)
      S_ARMED: begin
        wr_en   = trig_hit;
        wr_addr = '0;
      end
      S_CAPTURE: wr_en = (dcnt == '0);
      default: ;
    endcase
    xfer    = valid_q && rd.rd_ready;
    // A transfer of a non-final record immediately fetches the next one, so
    // the stream runs back-to-back while the output stays frozen on a stall.
    rd_ld   = rd_req || (xfer && !last_q);
    rd_addr = rd_req ? '0 : idx_q + ADDR_W'(1);
  end

  // Main sequencer: arm/trigger, decimated capture, readout handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      decim_q   <= '0;
      dcnt      <= '0;
      wr_ptr    <= '0;
      prev_sine <= '0;
      rd_start  <= 1'b0;
      rd_req    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      done_q   <= 1'b0;
      rd_start <= 1'b0;
      rd_req   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arm) begin
            decim_q   <= decim;
            dcnt      <= '0;
            wr_ptr    <= '0;
            prev_sine <= sine_in;
            state     <= trig_mode ? S_ARMED : S_CAPTURE;
          end
        end
        S_ARMED: begin
          prev_sine <= sine_in;
          if (trig_hit) begin
            wr_ptr <= ADDR_W'(1);
            dcnt   <= decim_q;
            state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (dcnt == '0) begin
            dcnt <= decim_q;
            if (wr_ptr == LAST_ADDR) begin
              state    <= S_READOUT;
              rd_start <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end else begin
            dcnt <= dcnt - DECIM_W'(1);
          end
        end
        default: begin
          rd_req <= rd_start;
          if (rd_req) begin
            valid_q <= 1'b1;
            idx_q   <= '0;
            last_q  <= 1'b0;
          end
          if (xfer) begin
            if (last_q) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= S_IDLE;
            end else begin
              idx_q  <= idx_q + ADDR_W'(1);
              last_q <= ((idx_q + ADDR_W'(1)) == LAST_ADDR);
            end
          end
        end
      endcase
    end
  end

  // Buffer write port.
  // NOTE: the array carries no reset so it maps onto block RAM; its contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Buffer registered read port; the register doubles as the rd_data holding stage.
  always_ff @(posedge clk) begin
    if (reset)      ram_q <= '0;
    else if (rd_ld) ram_q <= mem[rd_addr];
  end

  assign rd.rd_data  = ram_q;
  assign rd.rd_index = idx_q;
  assign rd.rd_valid = valid_q;
  assign rd.rd_last  = last_q;
  assign busy        = (state != S_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_dds_capture_readout.sv
// Self-checking bench for dds_capture_readout (DEPTH=8): packing table, directed
// trigger/decimation/backpressure/reset/arm-while-busy shots, and random shots
// compared against a shot-level reference model built from the input history.
`timescale 1ns/1ps
module tb_dds_capture_readout;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int DECIM_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                arm;
  logic                trig_mode;
  logic [DECIM_W-1:0]  decim;
  logic signed [15:0]  sine_in;
  logic signed [16:0]  tri_in;
  logic                pwm1_in;
  logic                pwm2_in;
  logic signed [3:0]   pwm3_in;
  logic signed [3:0]   pwm4_in;
  logic                busy;
  logic                done;

  dds_capture_readout_if #(.ADDR_W(ADDR_W)) rd ();

  dds_capture_readout #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DECIM_W(DECIM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .trig_mode (trig_mode),
    .decim     (decim),
    .sine_in   (sine_in),
    .tri_in    (tri_in),
    .pwm1_in   (pwm1_in),
    .pwm2_in   (pwm2_in),
    .pwm3_in   (pwm3_in),
    .pwm4_in   (pwm4_in),
    .busy      (busy),
    .done      (done),
    .rd        (rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] s;
    logic signed [16:0] t;
    logic               p1;
    logic               p2;
    logic signed [3:0]  p3;
    logic signed [3:0]  p4;
    logic [42:0]        exp;
  } vec_t;

  typedef struct packed {
    logic              v;
    logic [42:0]       d;
    logic [ADDR_W-1:0] i;
    logic              l;
    logic              b;
    logic              dn;
  } obs_t;

  vec_t tbl [DEPTH];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.v  = rd.rd_valid;
    o.d  = rd.rd_data;
    o.i  = rd.rd_index;
    o.l  = rd.rd_last;
    o.b  = busy;
    o.dn = done;
    return o;
  endfunction

  // Input record for cycle c of a shot (cycle 0 carries the arm pulse).
  function automatic logic [42:0] gen(input int kind, input int c);
    logic [42:0] v;
    logic [63:0] r;
    int          s;
    v = '0;
    case (kind)
      0: v = {16'(99 + c), 17'(c), c[0], c[1], 4'(c), 4'(-c)};
      1: begin
        case (c)
          0: s = -5;
          1: s = -3;
          2: s = -1;
          3: s = 0;
          default: s = 5 + 4 * (c - 4);
        endcase
        v = {16'(s), 17'(c * 7), 1'b0, 1'b1, 4'(c), 4'(c + 1)};
      end
      2: begin
        case (c)
          0: s = 3;
          1: s = 0;
          2: s = 2;
          3: s = -1;
          default: s = c;
        endcase
        v = {16'(s), 17'(-c), 1'b1, 1'b0, 4'(-c), 4'(c)};
      end
      3: v = {16'(c * 3), 17'(c - 1), c[1], c[0], 4'(c), 4'(c)};
      4: if (c >= 1 && c <= DEPTH)
           v = {tbl[c-1].s, tbl[c-1].t, tbl[c-1].p1, tbl[c-1].p2, tbl[c-1].p3, tbl[c-1].p4};
      default: begin
        r = {$urandom(), $urandom()};
        v = r[42:0];
      end
    endcase
    return v;
  endfunction

  // One complete shot: arm, capture, readout; optionally aborted by reset.
  task automatic run_shot(input string tag, input bit mode, input int dec, input int kind,
                          input int rkind, input bit arm_busy, input int abort_cap,
                          input int abort_rd);
    logic [42:0] hq[$];
    logic [42:0] got[$];
    logic [42:0] v;
    logic [42:0] g;
    obs_t        o;
    obs_t        po;
    bit          pr;
    bit          r;
    bit          exp_done;
    bit          fin;
    int          t0;
    int          first_v;
    int          ndone;
    int          tail;
    t0 = -1; first_v = -1; ndone = 0; tail = -1; exp_done = 0; pr = 0; fin = 0;
    po = '0;
    for (int c = 0; c < 800 && !fin; c++) begin
      o = sample();
      if (c == 0) check({tag, " busy_idle"}, o.b, 1'b0);
      if (c == 1) check({tag, " busy_after_arm"}, o.b, 1'b1);
      if (po.v && !pr) begin
        check({tag, " stall_valid"}, o.v, 1'b1);
        check({tag, " stall_data"}, o.d, po.d);
        check({tag, " stall_index"}, o.i, po.i);
        check({tag, " stall_last"}, o.l, po.l);
      end
      if (exp_done) begin
        check({tag, " done_after_last"}, o.dn, 1'b1);
        check({tag, " valid_after_last"}, o.v, 1'b0);
        check({tag, " busy_after_last"}, o.b, 1'b0);
        exp_done = 0;
        tail = 3;
      end
      if (o.dn) ndone++;
      if (o.v && first_v < 0) first_v = c;

      v = gen(kind, c);
      {sine_in, tri_in, pwm1_in, pwm2_in, pwm3_in, pwm4_in} = v;
      hq.push_back(v);
      if (c >= 1 && t0 < 0) begin
        if (!mode) t0 = 1;
        else if ($signed(hq[c-1][42:27]) < 0 && $signed(hq[c][42:27]) >= 0) t0 = c;
      end
      arm       = (c == 0) || (arm_busy && (c == 3 || c == first_v));
      trig_mode = (c == 0) ? mode : ~mode;
      decim     = (c == 0) ? DECIM_W'(dec) : DECIM_W'($urandom());
      case (rkind)
        0:       r = 1'b1;
        1:       r = (c % 3 == 0);
        default: r = $urandom_range(0, 1) == 1;
      endcase
      rd.rd_ready = r;
      reset = 1'b0;
      if (abort_cap >= 0 && t0 >= 0 && c == t0 + abort_cap * (dec + 1)) reset = 1'b1;
      if (abort_rd >= 0 && o.v && int'(o.i) == abort_rd) reset = 1'b1;
      if (!reset && o.v && r) begin
        check({tag, " xfer_index"}, o.i, got.size());
        check({tag, " xfer_last"}, o.l, got.size() == DEPTH - 1);
        got.push_back(o.d);
        if (o.l) exp_done = 1;
      end

      @(posedge clk); #1;

      if (reset) begin
        o = sample();
        check({tag, " rst_busy"}, o.b, 1'b0);
        check({tag, " rst_valid"}, o.v, 1'b0);
        check({tag, " rst_done"}, o.dn, 1'b0);
        check({tag, " rst_index"}, o.i, 0);
        check({tag, " rst_data"}, o.d, 0);
        reset = 1'b0;
        arm = 1'b0;
        return;
      end
      po = o;
      pr = r;
      if (tail > 0) begin
        tail--;
        if (tail == 0) fin = 1;
      end
    end
    arm = 1'b0;
    rd.rd_ready = 1'b0;

    check({tag, " completed"}, fin, 1'b1);
    check({tag, " record_count"}, got.size(), DEPTH);
    check({tag, " done_pulses"}, ndone, 1);
    check({tag, " trigger_seen"}, t0 >= 0, 1'b1);
    if (t0 >= 0) begin
      check({tag, " first_valid_cycle"}, first_v, t0 + (DEPTH - 1) * (dec + 1) + 3);
      for (int k = 0; k < got.size() && k < DEPTH; k++) begin
        g = got[k];
        if (t0 + k * (dec + 1) < hq.size())
          check({tag, " model_record"}, g, hq[t0 + k * (dec + 1)]);
        else
          check({tag, " model_record_range"}, 1'b0, 1'b1);
      end
    end
    if (got.size() == DEPTH) begin
      for (int k = 0; k < DEPTH; k++) begin
        g = got[k];
        case (kind)
          0: check({tag, " sine_counter"}, g[42:27], 100 + k);
          3: check({tag, " tri_decim"}, g[26:10], 3 * k);
          4: check({tag, " packing"}, g, tbl[k].exp);
          default: ;
        endcase
      end
      g = got[0];
      if (kind == 1) check({tag, " zc_rec0"}, g[42:27], 0);
      if (kind == 2) check({tag, " zc_late_rec0"}, g[42:27], 4);
      g = got[1];
      if (kind == 1) check({tag, " zc_rec1"}, g[42:27], 5);
    end
  endtask

  initial begin
    // Field-packing table: inputs and the 43-bit record they must produce.
    tbl[0] = '{s: 16'sd0,      t: 17'sd0,  p1: 1'b1, p2: 1'b0, p3: 4'sd0,  p4: 4'sd0,  exp: 43'h200};
    tbl[1] = '{s: 16'sd0,      t: 17'sd0,  p1: 1'b0, p2: 1'b0, p3: -4'sd2, p4: 4'sd0,  exp: 43'h0E0};
    tbl[2] = '{s: 16'sd0,      t: 17'sd0,  p1: 1'b0, p2: 1'b0, p3: 4'sd0,  p4: -4'sd1, exp: 43'h00F};
    tbl[3] = '{s: 16'sd0,      t: 17'sd1,  p1: 1'b0, p2: 1'b0, p3: 4'sd0,  p4: 4'sd0,  exp: 43'h400};
    tbl[4] = '{s: 16'sd0,      t: -17'sd1, p1: 1'b0, p2: 1'b0, p3: 4'sd0,  p4: 4'sd0,  exp: 43'h7FFFC00};
    tbl[5] = '{s: 16'sd1,      t: 17'sd0,  p1: 1'b0, p2: 1'b0, p3: 4'sd0,  p4: 4'sd0,  exp: 43'h8000000};
    tbl[6] = '{s: -16'sd32768, t: 17'sd0,  p1: 1'b0, p2: 1'b0, p3: 4'sd0,  p4: 4'sd0,  exp: 43'h40000000000};
    tbl[7] = '{s: 16'sh1234,   t: 17'sd0,  p1: 1'b1, p2: 1'b0, p3: -4'sd2, p4: 4'sd5,  exp: 43'h91A00002E5};

    reset = 1'b1; arm = 1'b1; trig_mode = 1'b0; decim = '0;
    sine_in = '0; tri_in = '0; pwm1_in = 1'b0; pwm2_in = 1'b0; pwm3_in = '0; pwm4_in = '0;
    rd.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset rd_valid", rd.rd_valid, 1'b0);
    check("reset rd_last", rd.rd_last, 1'b0);
    check("reset rd_index", rd.rd_index, 0);
    check("reset rd_data", rd.rd_data, 0);
    reset = 1'b0; arm = 1'b0;
    @(posedge clk); #1;

    run_shot("immediate",  1'b0, 0, 0, 0, 1'b0, -1, -1);
    run_shot("zero_cross", 1'b1, 0, 1, 0, 1'b0, -1, -1);
    run_shot("zc_late",    1'b1, 0, 2, 2, 1'b0, -1, -1);
    run_shot("decim2",     1'b0, 2, 3, 0, 1'b0, -1, -1);
    run_shot("backpress",  1'b0, 0, 4, 1, 1'b0, -1, -1);
    run_shot("abort_cap",  1'b0, 0, 0, 0, 1'b0,  4, -1);
    run_shot("after_cap",  1'b0, 0, 0, 0, 1'b0, -1, -1);
    run_shot("abort_rd",   1'b0, 0, 0, 1, 1'b0, -1,  3);
    run_shot("after_rd",   1'b0, 0, 0, 1, 1'b0, -1, -1);
    run_shot("arm_busy",   1'b0, 1, 5, 1, 1'b1, -1, -1);
    for (int n = 0; n < 6; n++)
      run_shot("random", $urandom_range(0, 1) == 1, $urandom_range(0, 3), 5, 2,
               $urandom_range(0, 1) == 1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_capture_readout.md
Name: dds_capture_readout

Overview:
- On-chip counterpart of the DDS output logger: captures the Top DDS outputs (Sine, Tri, PWM_1..4) into an internal buffer.
- Capture starts on a software arm plus trigger.
- After capture, the buffer is replayed one record per handshake over a valid/ready stream, for a UART/ILA-style formatter.
- Record order and field set match the per-cycle line order used by the simulation logger: sine, tri, pwm1, pwm2, pwm3, pwm4.

Parameters:
- DEPTH, 1024, number of records captured per shot (power of two, ≥4).
- ADDR_W, 10, log2(DEPTH).
- DECIM_W, 16, width of the decimation control.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle request to start a capture; honoured only in IDLE.
- trig_mode  in  1  0 = start immediately; 1 = start on a rising zero crossing of sine_in. Sampled on arm.
- decim  in  DECIM_W  store one sample every decim+1 cycles. Sampled on arm.
- sine_in  in  16  signed sine sample.
- tri_in  in  17  signed triangle sample.
- pwm1_in  in  1  PWM_1.
- pwm2_in  in  1  PWM_2.
- pwm3_in  in  4  signed PWM_3.
- pwm4_in  in  4  signed PWM_4.
- rd_data  out  43  record: {sine[42:27], tri[26:10], pwm1[9], pwm2[8], pwm3[7:4], pwm4[3:0]}.
- rd_index  out  ADDR_W  index of the record on rd_data (0 = first captured).
- rd_valid  out  1  rd_data/rd_index/rd_last are valid.
- rd_ready  in  1  sink accepts the current record.
- rd_last  out  1  high with record DEPTH-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last record is accepted.

Behaviour:
- Reset (synchronous, dominant over all inputs, including mid-capture or mid-readout):
  - State goes to IDLE.
  - All outputs go to 0: rd_data, rd_index, rd_valid, rd_last, busy, done.
  - Write pointer, read pointer and decimation counter clear.
  - Buffer contents are don't-care.
- States:
  - IDLE:
    - arm=1 latches trig_mode and decim.
    - Goes to CAPTURE if trig_mode=0, otherwise to ARMED.
    - busy rises the cycle after arm.
  - ARMED:
    - Each cycle registers prev_sine <= sine_in.
    - The trigger fires when prev_sine<0 and sine_in>=0. The first compare uses prev_sine as captured on the arm cycle.
    - On the trigger cycle, that cycle's inputs are written as record 0 and the state goes to CAPTURE.
  - CAPTURE:
    - The decimation counter reloads to decim after each write and decrements otherwise.
    - A write occurs when the counter is 0. For trig_mode=0, the first write is the first cycle in CAPTURE.
    - After the write at address DEPTH-1, the state goes to READOUT. The write pointer never wraps.
    - With decim=0 every cycle is stored, so a shot takes DEPTH consecutive cycles.
  - READOUT:
    - Synchronous-read buffer with 1-cycle read latency.
    - rd_valid first rises 2 cycles after entering READOUT.
    - rd_data, rd_index and rd_last stay stable while rd_valid=1 and rd_ready=0.
    - A transfer is the cycle with rd_valid=1 and rd_ready=1. The next record is presented with at most 1 bubble. The implementation may prefetch to achieve back-to-back transfers; back-to-back is preferred but not required.
    - After the transfer with rd_last=1, the next cycle has rd_valid=0 and done=1, and the state goes to IDLE with busy=0 on that same cycle.
- arm while busy is ignored (no restart, no error).
- rd_ready is ignored when rd_valid=0.
- Buffer width is 43 bits, inferred as block RAM. Fields are stored verbatim, with no sign extension or rescaling.

Test Plan:
- Immediate capture, DEPTH=8:
  - Stimulus: reset 3 cycles; arm with trig_mode=0, decim=0; sine_in driven as a counter 100,101,…; rd_ready held 1.
  - Required: 8 records with sine 100..107 in index order 0..7; rd_last only at index 7; done pulses once; busy ends.
- Zero-crossing trigger:
  - Stimulus: trig_mode=1; sine_in sequence −3,−1,0,5,9… applied after arm.
  - Required: record 0 sine = 0, record 1 = 5.
  - Also: sine_in sequence 0,2,−1 produces no trigger until the next negative-to-non-negative step.
- Decimation:
  - Stimulus: decim=2; counter on tri_in starting at 0.
  - Required: stored tri values are 0,3,6,…,21.
  - Required: the capture phase lasts 22 cycles from first write to last write.
- Backpressure:
  - Stimulus: rd_ready toggles 1,0,0,1,…
  - Required: no record is dropped or duplicated; rd_data and rd_index are held constant across the stall cycles.
  - Required: field packing checks out with pwm3_in=−2 → rd_data[7:4]=4'b1110, and pwm1=1 → bit 9 set.
- Reset mid-operation:
  - Stimulus: assert reset at capture record 4, and separately at readout index 3.
  - Required: the next cycle shows busy=0, rd_valid=0, done=0.
  - Required: a fresh arm then yields a full 8-record shot starting at index 0.
- Arm while busy:
  - Stimulus: pulse arm during CAPTURE and during READOUT.
  - Required: the sequence is unaffected, and exactly one done pulse is produced.
